// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Raster timing master for 640x480@60 Hz VGA on a 25 MHz pixel clock.
//   Publishes the current visible pixel coordinate to the renderer, takes the
//   renderer's colour PIX_LAT cycles later, and drives sync, blank and colour
//   to the board pins. Sync, DE and colour all reach the pins together,
//   PIX_LAT+1 cycles after the counter value they belong to.
//
// Ports
//   vga_clk      pixel clock
//   rst_sys_n    asynchronous active-low reset
//   pix_data     renderer colour {R,G,B}, valid PIX_LAT cycles after x/y
//   x, y         visible coordinate (0 outside the visible area)
//   pix_req      x/y address a visible pixel
//   frame_start  one-cycle pulse once per frame (registered, not delayed)
//   vga_hs/vs    active-low syncs, aligned with colour
//   vga_de       display enable, aligned with colour
//   vga_r/g/b    colour, forced to zero while blanked
module vga_timing_ctrl #(
    parameter int unsigned H_VALID = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VALID = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned PIX_LAT = 1
) (
    input  logic        vga_clk,
    input  logic        rst_sys_n,
    input  logic [11:0] pix_data,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        pix_req,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_VALID + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VALID + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS_END  = 10'(H_VALID);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VALID + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VALID + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VALID);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VALID + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VALID + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    logic [9:0]         h_cnt_q, h_cnt_d;
    logic [9:0]         v_cnt_q, v_cnt_d;
    logic               active;
    logic               hs_raw, vs_raw, de_raw;
    logic               frame_start_q, frame_start_d;
    logic [PIX_LAT-1:0] hs_dly_q, hs_dly_d;
    logic [PIX_LAT-1:0] vs_dly_q, vs_dly_d;
    logic [PIX_LAT-1:0] de_dly_q, de_dly_d;
    logic               vga_hs_q, vga_hs_d;
    logic               vga_vs_q, vga_vs_d;
    logic               vga_de_q, vga_de_d;
    logic [11:0]        rgb_q, rgb_d;

    // Raster counters: v advances (and wraps) on the same edge h wraps.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Combinational decode straight from the registered counters.
    always_comb begin
        active        = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
        hs_raw        = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
        vs_raw        = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
        de_raw        = active;
        pix_req       = active;
        x             = active ? h_cnt_q : '0;
        y             = active ? v_cnt_q[8:0] : '0;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Delay line matching the renderer latency; stage 0 takes the raw decode.
    if (PIX_LAT == 1) begin : g_dly_one
        always_comb begin
            hs_dly_d = hs_raw;
            vs_dly_d = vs_raw;
            de_dly_d = de_raw;
        end
    end else begin : g_dly_many
        always_comb begin
            hs_dly_d = {hs_dly_q[PIX_LAT-2:0], hs_raw};
            vs_dly_d = {vs_dly_q[PIX_LAT-2:0], vs_raw};
            de_dly_d = {de_dly_q[PIX_LAT-2:0], de_raw};
        end
    end

    // Pin stage: the last delay stage lines up with pix_data, so one more
    // register puts sync, DE and gated colour on the same edge.
    always_comb begin
        vga_hs_d = hs_dly_q[PIX_LAT-1];
        vga_vs_d = vs_dly_q[PIX_LAT-1];
        vga_de_d = de_dly_q[PIX_LAT-1];
        rgb_d    = de_dly_q[PIX_LAT-1] ? pix_data : '0;
    end

    always_ff @(posedge vga_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            hs_dly_q      <= '1;
            vs_dly_q      <= '1;
            de_dly_q      <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_de_q      <= 1'b0;
            rgb_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            de_dly_q      <= de_dly_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_de_q      <= vga_de_d;
            rgb_q         <= rgb_d;
        end
    end

    assign frame_start           = frame_start_q;
    assign vga_hs                = vga_hs_q;
    assign vga_vs                = vga_vs_q;
    assign vga_de                = vga_de_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
//   Directed bench for vga_timing_ctrl. Three instances share clock and reset:
//   u_a full timing with PIX_LAT=1, u_b full timing with PIX_LAT=3, and u_s a
//   shrunken raster (16x9, PIX_LAT=2) so whole frames fit in a short run.
//   Renderer models for u_a/u_b register {2'b00,x}; u_s sees constant 12'hFFF.
module tb_vga_timing_ctrl;

    logic vga_clk = 1'b0;
    logic rst_sys_n;
    always #20 vga_clk = ~vga_clk;

    logic [11:0] pix_a, pix_b, pix_s, p1_b, p2_b;
    logic [9:0]  x_a, x_b, x_s;
    logic [8:0]  y_a, y_b, y_s;
    logic        req_a, req_b, req_s;
    logic        fs_a, fs_b, fs_s;
    logic        hs_a, hs_b, hs_s;
    logic        vs_a, vs_b, vs_s;
    logic        de_a, de_b, de_s;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_s, g_s, b_s;
    logic [11:0] rgb_a, rgb_b, rgb_s;

    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};
    assign rgb_s = {r_s, g_s, b_s};

    vga_timing_ctrl #(.PIX_LAT(1)) u_a (
        .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_a),
        .x(x_a), .y(y_a), .pix_req(req_a), .frame_start(fs_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_timing_ctrl #(.PIX_LAT(3)) u_b (
        .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_b),
        .x(x_b), .y(y_b), .pix_req(req_b), .frame_start(fs_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    vga_timing_ctrl #(
        .H_VALID(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VALID(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .PIX_LAT(2)
    ) u_s (
        .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_s),
        .x(x_s), .y(y_s), .pix_req(req_s), .frame_start(fs_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s)
    );

    // Renderer models: 1-stage for u_a, 3-stage for u_b.
    always @(posedge vga_clk) begin
        pix_a <= {2'b00, x_a};
        p1_b  <= {2'b00, x_b};
        p2_b  <= p1_b;
        pix_b <= p2_b;
    end

    int passed, total, failed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    int bad, early_bad, fs_extra_a, vs_bad_a;
    int first_de_a, last_de_a, de_cnt_a, fall1_a, fall2_a, hs_low_a;
    int first_de_b, last_de_b, fall1_b;
    int fs1_s, fs2_s, hfall_s, hs_low_s, vfall_s, vs_low_s, de_cnt_s, vblank_bad_s, blank_bad_s;
    int m;
    logic [11:0] first_rgb_a, last_rgb_a, first_rgb_b, last_rgb_b;
    logic hs_prev_a, hs_prev_b, hs_prev_s, vs_prev_s;

    initial begin
        passed = 0; total = 0; failed = 0;
        rst_sys_n = 1'b0;
        pix_s     = 12'hFFF;

        // Reset held for 5 cycles: every output at its reset value.
        bad = 0;
        repeat (5) begin
            tick();
            if (hs_a !== 1'b1 || vs_a !== 1'b1 || de_a !== 1'b0 || rgb_a !== 12'h000 || fs_a !== 1'b0) bad++;
            if (hs_b !== 1'b1 || vs_b !== 1'b1 || de_b !== 1'b0 || rgb_b !== 12'h000 || fs_b !== 1'b0) bad++;
            if (x_b !== 10'd0 || y_b !== 9'd0 || req_b !== 1'b1) bad++;
            if (hs_s !== 1'b1 || vs_s !== 1'b1 || de_s !== 1'b0 || rgb_s !== 12'h000 || fs_s !== 1'b0) bad++;
            if (x_s !== 10'd0 || y_s !== 9'd0 || req_s !== 1'b1) bad++;
        end
        chk("reset_hold_all", bad, 0);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_de", de_a, 0);
        chk("rst_rgb", rgb_a, 0);
        chk("rst_fs", fs_a, 0);
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_req", req_a, 1);

        // Release between edges; n counts edges since release.
        rst_sys_n = 1'b1;
        early_bad = 0; fs_extra_a = 0; vs_bad_a = 0;
        first_de_a = -1; last_de_a = -1; de_cnt_a = 0; fall1_a = -1; fall2_a = -1; hs_low_a = 0;
        first_de_b = -1; last_de_b = -1; fall1_b = -1;
        fs1_s = -1; fs2_s = -1; hfall_s = -1; hs_low_s = 0; vfall_s = -1; vs_low_s = 0;
        de_cnt_s = 0; vblank_bad_s = 0; blank_bad_s = 0;
        first_rgb_a = '0; last_rgb_a = '0; first_rgb_b = '0; last_rgb_b = '0;
        hs_prev_a = 1'b1; hs_prev_b = 1'b1; hs_prev_s = 1'b1; vs_prev_s = 1'b1;

        for (int n = 1; n <= 1680; n++) begin
            tick();
            if (n == 1) begin
                chk("first_fs_a", fs_a, 1);
                chk("first_x_a", x_a, 1);
            end
            if (n == 639) chk("x_last_a", x_a, 639);
            if (n == 640) begin
                chk("req_fp_a", req_a, 0);
                chk("x_fp_a", x_a, 0);
            end
            if (n == 805) begin
                chk("x_row1_a", x_a, 5);
                chk("y_row1_a", y_a, 1);
            end
            if (n <= 1 && (hs_a !== 1'b1 || vs_a !== 1'b1 || de_a !== 1'b0 || rgb_a !== 12'h000)) early_bad++;
            if (n <= 3 && (hs_b !== 1'b1 || vs_b !== 1'b1 || de_b !== 1'b0 || rgb_b !== 12'h000)) early_bad++;
            if (n <= 2 && (hs_s !== 1'b1 || vs_s !== 1'b1 || de_s !== 1'b0)) early_bad++;

            // u_a
            if (n >= 2 && fs_a === 1'b1) fs_extra_a++;
            if (vs_a !== 1'b1) vs_bad_a++;
            if (de_a === 1'b1 && first_de_a < 0) begin
                first_de_a  = n;
                first_rgb_a = rgb_a;
            end
            if (n < 800 && de_a === 1'b1) begin
                de_cnt_a++;
                last_de_a  = n;
                last_rgb_a = rgb_a;
            end
            if (hs_prev_a === 1'b1 && hs_a === 1'b0) begin
                if (fall1_a < 0) fall1_a = n;
                else if (fall2_a < 0) fall2_a = n;
            end
            if (n < 800 && hs_a === 1'b0) hs_low_a++;
            hs_prev_a = hs_a;

            // u_b
            if (de_b === 1'b1 && first_de_b < 0) begin
                first_de_b  = n;
                first_rgb_b = rgb_b;
            end
            if (n < 800 && de_b === 1'b1) begin
                last_de_b  = n;
                last_rgb_b = rgb_b;
            end
            if (hs_prev_b === 1'b1 && hs_b === 1'b0 && fall1_b < 0) fall1_b = n;
            hs_prev_b = hs_b;

            // u_s
            if (fs_s === 1'b1) begin
                if (fs1_s < 0) fs1_s = n;
                else if (fs2_s < 0) fs2_s = n;
            end
            if (hs_prev_s === 1'b1 && hs_s === 1'b0 && hfall_s < 0) hfall_s = n;
            if (n < 16 && hs_s === 1'b0) hs_low_s++;
            hs_prev_s = hs_s;
            if (vs_prev_s === 1'b1 && vs_s === 1'b0 && vfall_s < 0) vfall_s = n;
            if (n < 144 && vs_s === 1'b0) vs_low_s++;
            vs_prev_s = vs_s;
            if (n >= 3 && n < 147 && de_s === 1'b1) de_cnt_s++;
            if (n >= 3) begin
                m = (n - 3) % 144;
                if ((m / 16) >= 4 && de_s !== 1'b0) vblank_bad_s++;
            end
            if (rgb_s !== (de_s === 1'b1 ? 12'hFFF : 12'h000)) blank_bad_s++;

            // Last sample before the mid-frame reset.
            if (n == 1680) begin
                chk("pre_rst_de_a", de_a, 1);
                chk("pre_rst_rgb_a", rgb_a, 12'h04E);
                chk("pre_rst_y_a", y_a, 2);
                chk("pre_rst_vs_s", vs_s, 0);
            end
        end

        chk("early_reset_vals", early_bad, 0);
        chk("fs_once_a", fs_extra_a, 0);
        chk("vs_idle_a", vs_bad_a, 0);
        chk("first_de_a", first_de_a, 2);
        chk("first_rgb_a", first_rgb_a, 12'h000);
        chk("last_de_a", last_de_a, 641);
        chk("last_rgb_a", last_rgb_a, 12'h27F);
        chk("de_count_a", de_cnt_a, 640);
        chk("hs_fall1_a", fall1_a, 658);
        chk("hs_fall2_a", fall2_a, 1458);
        chk("hs_low_a", hs_low_a, 96);
        chk("first_de_b", first_de_b, 4);
        chk("first_rgb_b", first_rgb_b, 12'h000);
        chk("last_de_b", last_de_b, 643);
        chk("last_rgb_b", last_rgb_b, 12'h27F);
        chk("hs_fall1_b", fall1_b, 660);
        chk("fs1_s", fs1_s, 1);
        chk("fs2_s", fs2_s, 145);
        chk("hs_fall_s", hfall_s, 13);
        chk("hs_low_s", hs_low_s, 3);
        chk("vs_fall_s", vfall_s, 83);
        chk("vs_low_s", vs_low_s, 32);
        chk("de_count_s", de_cnt_s, 32);
        chk("vblank_de_s", vblank_bad_s, 0);
        chk("blank_rgb_s", blank_bad_s, 0);

        // Asynchronous reset between edges: outputs clear before the next edge.
        #5;
        rst_sys_n = 1'b0;
        #1;
        chk("mid_rst_de_a", de_a, 0);
        chk("mid_rst_rgb_a", rgb_a, 0);
        chk("mid_rst_hs_a", hs_a, 1);
        chk("mid_rst_x_a", x_a, 0);
        chk("mid_rst_y_a", y_a, 0);
        chk("mid_rst_req_a", req_a, 1);
        chk("mid_rst_vs_s", vs_s, 1);
        tick();
        tick();
        rst_sys_n = 1'b1;

        early_bad = 0;
        fs1_s = -1; fall1_a = -1; fall1_b = -1; first_de_a = -1;
        hs_prev_a = 1'b1; hs_prev_b = 1'b1;
        for (int n = 1; n <= 700; n++) begin
            tick();
            if (fs_a === 1'b1 && first_de_a < 0) first_de_a = n;
            if (fs_s === 1'b1 && fs1_s < 0) fs1_s = n;
            if (n <= 3 && (hs_b !== 1'b1 || vs_b !== 1'b1 || de_b !== 1'b0 || rgb_b !== 12'h000)) early_bad++;
            if (hs_prev_a === 1'b1 && hs_a === 1'b0 && fall1_a < 0) fall1_a = n;
            if (hs_prev_b === 1'b1 && hs_b === 1'b0 && fall1_b < 0) fall1_b = n;
            hs_prev_a = hs_a;
            hs_prev_b = hs_b;
        end
        chk("post_rst_fs_a", first_de_a, 1);
        chk("post_rst_fs_s", fs1_s, 1);
        chk("post_rst_stale_b", early_bad, 0);
        chk("post_rst_hs_fall_a", fall1_a, 658);
        chk("post_rst_hs_fall_b", fall1_b, 660);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Presents the current pixel coordinate (x, y) to the pixel renderer and accepts the renderer's registered 12-bit colour PIX_LAT cycles later.
- Aligns sync and blanking to that colour and drives the board VGA pins.
- It is the consumer/timing master at the other end of the renderer's x/y -> pix_data interface.

Parameters:
- H_VALID, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_VALID, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_LAT, 1, renderer latency in cycles from x/y to pix_data; legal range 1..4

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- rst_sys_n  input  1  asynchronous, active-low reset
- pix_data  input  12  renderer colour {R[3:0],G[3:0],B[3:0]}, valid PIX_LAT cycles after matching x/y
- x  output  10  current visible column 0..639; 0 when not visible
- y  output  9  current visible row 0..479; 0 when not visible
- pix_req  output  1  high when x/y address a visible pixel
- frame_start  output  1  one-cycle pulse at h_cnt==0 && v_cnt==0
- vga_hs  output  1  horizontal sync, active low
- vga_vs  output  1  vertical sync, active low
- vga_de  output  1  display enable aligned with vga_r/g/b
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue

Behaviour:
- Internal counters h_cnt[9:0] (0..799) and v_cnt[9:0] (0..524), both registered.
- h_cnt increments every cycle and wraps 799->0. v_cnt increments when h_cnt wraps, and wraps 524->0 on that same edge.
- Line order: visible 0..639, FP 640..655, sync 656..751, BP 752..799.
- Frame order: visible 0..479, FP 480..489, sync 490..491, BP 492..524.
- Totals are derived from parameters (H_TOTAL = sum of H_*, V_TOTAL = sum of V_*); comparisons use these sums, never hard-coded constants.
- Coordinate outputs:
  - active = (h_cnt < H_VALID) && (v_cnt < V_VALID).
  - pix_req = active; x = active ? h_cnt : 0; y = active ? v_cnt[8:0] : 0.
  - All are decoded combinationally from the registered counters and change only after vga_clk edges.
- Sync/blank pipeline:
  - Raw signals: hs_raw = !(656 <= h_cnt < 752); vs_raw = !(490 <= v_cnt < 492); de_raw = active.
  - These pass through a PIX_LAT-deep shift register so they align with pix_data.
- Output stage (one register level): vga_hs/vga_vs/vga_de take the delayed raw values.
  - {vga_r,vga_g,vga_b} = delayed de ? pix_data : 12'h000.
  - Total latency from counter value to pins is PIX_LAT+1 cycles, identical for sync, de and colour.
- frame_start is a registered decode of the counters; it is not delayed. It is high for exactly one cycle per frame (period 420000 cycles).
- Reset (asynchronous assert, synchronous deassert behaviour is the system's concern):
  - h_cnt=0, v_cnt=0; all delay-line stages set to hs=1, vs=1, de=0.
  - vga_hs=1, vga_vs=1, vga_de=0, RGB=0, frame_start=0.
  - x=0, y=0 and pix_req=1 follow combinationally from counters at 0.
  - Reset mid-frame aborts the frame immediately; after release, timing restarts at pixel (0,0) with no stale delay-line contents reaching the pins.
- pix_data is ignored (RGB forced 0) whenever delayed de is low, regardless of value.
- No back-pressure: the renderer must meet PIX_LAT every cycle.

Test Plan:
- Reset release: hold rst_sys_n low 5 cycles, release -> first edge after release: frame_start=1, h_cnt advances to 1. vga_hs=vga_vs=1 and vga_de=0 throughout reset and the first PIX_LAT+1 cycles.
- Horizontal timing (PIX_LAT=1): vga_hs low for exactly 96 consecutive cycles, falling 2 cycles after h_cnt reaches 656, period 800. vga_de high 640 cycles per visible line.
- Vertical timing: vga_vs low exactly 1600 cycles (2 lines), period 420000. frame_start pulses every 420000 cycles. vga_de never high on lines 480..524.
- Data alignment: model renderer registers pix_data={2'b00,x} with 1-cycle latency (PIX_LAT=1). First vga_de cycle of row 0 shows RGB 12'h000, the last shows 12'h27F, with no off-by-one. Repeat with PIX_LAT=3 and a 3-stage model.
- Blanking: drive pix_data constant 12'hFFF -> RGB=12'h000 on every cycle where vga_de=0, and 12'hFFF on every cycle where vga_de=1.
- Asynchronous reset mid-frame at h_cnt=300, v_cnt=200, asserted between clock edges -> outputs take reset values before the next edge. After release, the first frame_start arrives one cycle later and the next vga_hs fall occurs 657+PIX_LAT cycles after release.
